buffer_tx_serializer: RTL and testbench

- Downstream drain stage for the 8-deep, 16-bit memory buffer.
- Mirrors buffer occupancy by snooping the writer's strobe, then pulls words out with a one-cycle read strobe.
- Sends each word on a single-wire asynchronous serial line: start bit, 16 data bits LSB first, stop bit.
- Flags writes that overrun unread buffer contents.

---
 rtl/buffer_tx_serializer_if.sv | 16 +
 rtl/buffer_tx_serializer.sv | 127 ++++++++++++
 tb/tb_buffer_tx_serializer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_tx_serializer_if.sv
// buffer_tx_serializer_if: buffer strobes, read data and serial-side status of the drain stage.
interface buffer_tx_serializer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              buf_w;
  logic [DATA_W-1:0] buf_data;
  logic              clr_ovf;
  logic              buf_r;
  logic              tx;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  modport master (output buf_w, buf_data, clr_ovf, input buf_r, tx, busy, count, ovf);
  modport slave  (input buf_w, buf_data, clr_ovf, output buf_r, tx, busy, count, ovf);
endinterface

// File: rtl/buffer_tx_serializer.sv
// buffer_tx_serializer: mirrors buffer occupancy, reads words out and sends start/DATA_W bits LSB first/stop.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module buffer_tx_serializer #(
  parameter int DEPTH        = 8,
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input logic                   clk,
  input logic                   rst,
  buffer_tx_serializer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
  logic r_par;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [CLK_W-1:0]  r_clk;
  logic [BIT_W-1:0]  r_bit;
  logic [CNT_W-1:0]  r_count;
  logic              r_tx;
  logic              r_buf_r;
  logic              r_busy;
  logic              r_ovf;
  logic              w_tick;
  logic              w_inc;
  logic              w_dec;
  logic              w_full;

  assign w_tick = r_clk == CLK_LAST;
  assign w_inc  = bus.buf_w & ~r_buf_r;
  assign w_dec  = r_buf_r & ~bus.buf_w;
  assign w_full = r_count == FULL;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_clk   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_buf_r <= 1'b0;
      r_busy  <= 1'b0;
`ifdef TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_buf_r <= 1'b0;
      r_clk   <= w_tick ? '0 : r_clk + 1'b1;
      case (r_state)
        IDLE: begin
          r_clk <= '0;
          if (r_count != '0) begin
            r_state <= LOAD;
            r_buf_r <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_clk   <= '0;
          r_shift <= bus.buf_data;
`ifdef TX_PARITY_EN
          r_par   <= ^bus.buf_data;
`endif
          r_state <= START;
          r_tx    <= 1'b0;
        end
        START: if (w_tick) begin
          r_state <= DATA;
          r_tx    <= r_shift[0];
        end
        DATA: if (w_tick) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 1'b1;
          if (r_bit == BIT_LAST) begin
            r_bit <= '0;
`ifdef TX_PARITY_EN
            r_state <= PARITY;
            r_tx    <= r_par;
`else
            r_state <= STOP;
            r_tx    <= 1'b1;
`endif
          end else r_tx <= r_shift[1];
        end
`ifdef TX_PARITY_EN
        PARITY: if (w_tick) begin
          r_state <= STOP;
          r_tx    <= 1'b1;
        end
`endif
        STOP: if (w_tick) begin
          r_state <= (r_count != '0) ? LOAD : IDLE;
          r_buf_r <= r_count != '0;
          r_busy  <= r_count != '0;
        end
        default: r_state <= IDLE;
      endcase
    end

  // a write into a full, undrained buffer overwrites an unread slot, so the count saturates
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_inc && !w_full) r_count <= r_count + 1'b1;
      else if (w_dec && r_count != '0) r_count <= r_count - 1'b1;
      r_ovf <= (w_inc & w_full) | (r_ovf & ~bus.clr_ovf);
    end

  assign bus.buf_r = r_buf_r;
  assign bus.tx    = r_tx;
  assign bus.busy  = r_busy;
  assign bus.count = r_count;
  assign bus.ovf   = r_ovf;
endmodule

// File: tb/tb_buffer_tx_serializer.sv
// tb_buffer_tx_serializer: directed steps with a frame scoreboard fed by buffer writes and drained by a serial decoder.
module tb_buffer_tx_serializer;
`ifdef TX_PARITY_EN
  localparam int NB = 19;
`else
  localparam int NB = 18;
`endif
  localparam int FC = NB * 4;

  logic clk;
  logic rst;
  logic [15:0] wdata;
  logic [15:0] mem [8];
  logic [2:0]  rp, wp;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  int fall_cyc[$];
  int fall_cnt[$];
  logic [FC-1:0] mon_obs;
  logic [15:0] mon_word;
  logic mon_abort;

  buffer_tx_serializer_if #(.DATA_W(16), .CNT_W(4)) bus ();

  buffer_tx_serializer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst)
    if (!rst) begin
      rp <= '0;
      wp <= '0;
    end else begin
      if (bus.buf_w) begin
        mem[wp] <= wdata;
        wp <= wp + 1'b1;
      end
      if (bus.buf_r) rp <= rp + 1'b1;
    end

  assign bus.buf_data = bus.buf_r ? mem[rp] : '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FC-1:0] frame_of(input logic [15:0] w);
    logic [FC-1:0] v;
    int j;
    for (int i = 0; i < FC; i++) begin
      j = i / 4;
      if (j == 0) v[i] = 1'b0;
      else if (j <= 16) v[i] = w[j-1];
      else v[i] = 1'b1;
`ifdef TX_PARITY_EN
      if (j == 17) v[i] = ^w;
`endif
    end
    return v;
  endfunction

  // serial decoder: samples every bit-cycle of a frame on the falling clock edge
  initial forever begin
    @(negedge bus.tx);
    if (rst === 1'b1) begin
      mon_abort = 1'b0;
      for (int i = 0; i < FC; i++) begin
        @(negedge clk);
        if (!rst) begin
          mon_abort = 1'b1;
          break;
        end
        if (i == 0) begin
          fall_cyc.push_back(cyc);
          fall_cnt.push_back(int'(bus.count));
        end
        mon_obs[i] = bus.tx;
      end
      if (!mon_abort) begin
        chk("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          for (int b = 0; b < 16; b++) mon_word[b] = mon_obs[4*(b+1)+1];
          chk("frame_word", mon_word, exp_q[0]);
          chk("frame_bits", mon_obs, frame_of(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    wdata = d;
    bus.buf_w = 1'b1;
    exp_q.push_back(d);
    step();
    bus.buf_w = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int t);
    int k = 0;
    while ((bus.busy || exp_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk("drain_in_budget", k < budget, 1'b1);
    t = cyc;
  endtask

  initial begin
    int tn, t_end;
    rst = 1'b0;
    bus.buf_w = 1'b0;
    bus.clr_ovf = 1'b0;
    wdata = '0;
    step();
    chk("reset_state", {bus.tx, bus.busy, bus.count, bus.buf_r, bus.ovf}, 8'b1_0_0000_0_0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_state", {bus.tx, bus.busy, bus.count, bus.buf_r}, 7'b1_0_0000_0);
    end

    // single word
    wr(16'hA5C3);
    chk("single_cnt_n", bus.count, 4'd1);
    chk("single_bufr_n", bus.buf_r, 1'b0);
    step();
    chk("single_bufr_n1", {bus.buf_r, bus.tx, bus.busy}, 3'b111);
    step();
    chk("single_n2", {bus.buf_r, bus.tx, bus.count}, 6'b0_0_0000);
    repeat (FC - 1) step();
    chk("single_busy_last", bus.busy, 1'b1);
    step();
    chk("single_done", {bus.busy, bus.tx}, 2'b01);

    // burst queued behind a carrier frame
    fall_cyc.delete();
    fall_cnt.delete();
    wr(16'h5A5A);
    repeat (10) step();
    wr(16'h0001);
    wr(16'h8000);
    wr(16'hFFFF);
    chk("burst_cnt3", bus.count, 4'd3);
    wait_idle(600, t_end);
    chk("burst_frames", fall_cyc.size(), 4);
    if (fall_cyc.size() == 4) begin
      for (int k = 1; k < 4; k++) begin
        chk("burst_gap", fall_cyc[k] - fall_cyc[k-1], FC + 1);
        chk("burst_cnt", fall_cnt[k], 3 - k);
      end
    end

    // write during LOAD while count==2
    wr(16'h1111);
    chk("load_cnt1", bus.count, 4'd1);
    wr(16'h2222);
    chk("load_in_load", {bus.buf_r, bus.count}, 5'b1_0010);
    wr(16'h3333);
    chk("load_cnt_stays", {bus.buf_r, bus.count}, 5'b0_0010);
    wait_idle(600, t_end);

    // overrun while the line is busy, then reset mid-frame
    wr(16'hC05E);
    tn = cyc;
    repeat (6) step();
    for (int i = 0; i < 8; i++) wr(16'(i));
    chk("ovf_full", {bus.count, bus.ovf}, 5'b1000_0);
    wr(16'hBEEF);
    chk("ovf_set", {bus.count, bus.ovf}, 5'b1000_1);
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    chk("ovf_clr", {bus.count, bus.ovf}, 5'b1000_0);
    bus.clr_ovf = 1'b1;
    wr(16'hCAFE);
    bus.clr_ovf = 1'b0;
    chk("ovf_set_wins", {bus.count, bus.ovf}, 5'b1000_1);
    while (cyc < tn + 35) step();
    #1;
    chk("pre_reset_bit7", {bus.tx, bus.busy}, 2'b01);
    rst = 1'b0;
    #1;
    chk("async_reset", {bus.tx, bus.busy, bus.count, bus.buf_r, bus.ovf}, 8'b1_0_0000_0_0);
    step();
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_reset_idle", {bus.tx, bus.busy, bus.count, bus.buf_r}, 7'b1_0_0000_0);
    end

    // recovery frame; also the parity case when enabled
    fall_cyc.delete();
    fall_cnt.delete();
    wr(16'h0007);
    wait_idle(300, t_end);
    chk("final_frames", fall_cyc.size(), 1);
    if (fall_cyc.size() == 1) chk("frame_len", t_end - fall_cyc[0], FC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
